// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//    div_state_t : FSM state encoding (IDLE, BUSY, FIX)
//    DIV_WIDTH   : datapath width
//    DIV_ITER    : restoring iterations per divide
//    DIV_CNT_W   : iteration counter width
package div_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, FIX} div_state_t;
   localparam int DIV_WIDTH = 32;
   localparam int DIV_ITER  = 32;
   localparam int DIV_CNT_W = $clog2(DIV_ITER);
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration.
//    rem_i [DIV_WIDTH:0]   : partial remainder in
//    quo_i [DIV_WIDTH-1:0] : quotient / remaining dividend bits in
//    dvs_i [DIV_WIDTH-1:0] : divisor
//    rem_o, quo_o          : next remainder and quotient
module div_step
   import div_pkg::*;
(
   input  logic [DIV_WIDTH:0]   rem_i,
   input  logic [DIV_WIDTH-1:0] quo_i,
   input  logic [DIV_WIDTH-1:0] dvs_i,
   output logic [DIV_WIDTH:0]   rem_o,
   output logic [DIV_WIDTH-1:0] quo_o
);
   logic [DIV_WIDTH:0]   shf;
   logic [DIV_WIDTH+1:0] trial;
   always_comb begin
      shf   = {rem_i[DIV_WIDTH-1:0], quo_i[DIV_WIDTH-1]};
      // extra top bit of trial is the borrow: set means the subtraction went negative
      trial = {1'b0, shf} - {2'b00, dvs_i};
      rem_o = trial[DIV_WIDTH+1] ? shf : trial[DIV_WIDTH:0];
      quo_o = {quo_i[DIV_WIDTH-2:0], ~trial[DIV_WIDTH+1]};
   end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: 32-cycle restoring divider with sign fix-up, cancel and async active-low reset.
//    clk, rst            : clock, asynchronous active-low reset
//    div_begin           : start request (level), sampled in IDLE
//    div_sign            : negate final quotient
//    div_dividend_sign   : negate final remainder
//    div_dividend        : dividend magnitude
//    div_divisor         : divisor magnitude
//    div_cancel          : synchronous abort
//    div_quotient        : sign-corrected quotient, held until next result
//    div_remainder       : sign-corrected remainder, held until next result
//    div_done            : one-cycle result pulse
//    div_busy            : operation in progress (BUSY or FIX)
module seq_divider
   import div_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 div_begin,
   input  logic                 div_sign,
   input  logic                 div_dividend_sign,
   input  logic [DIV_WIDTH-1:0] div_dividend,
   input  logic [DIV_WIDTH-1:0] div_divisor,
   input  logic                 div_cancel,
   output logic [DIV_WIDTH-1:0] div_quotient,
   output logic [DIV_WIDTH-1:0] div_remainder,
   output logic                 div_done,
   output logic                 div_busy
);
   div_state_t           state_q, state_d;
   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
   logic [DIV_WIDTH:0]   rem_q, rem_d, step_rem;
   logic [DIV_WIDTH-1:0] quo_q, quo_d, step_quo;
   logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
   logic [DIV_WIDTH-1:0] qres_q, qres_d, rres_q, rres_d;
   logic                 sgn_q, sgn_d, dsg_q, dsg_d;
   div_step u_step (
      .rem_i (rem_q),
      .quo_i (quo_q),
      .dvs_i (dvs_q),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dvs_d    = dvs_q;
      sgn_d    = sgn_q;
      dsg_d    = dsg_q;
      qres_d   = qres_q;
      rres_d   = rres_q;
      div_done = 1'b0;
      case (state_q)
         IDLE: if (div_begin && !div_cancel) begin
            state_d = BUSY;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = div_dividend;
            dvs_d   = div_divisor;
            sgn_d   = div_sign;
            dsg_d   = div_dividend_sign;
         end
         BUSY: if (div_cancel) state_d = IDLE;
         else begin
            rem_d   = step_rem;
            quo_d   = step_quo;
            state_d = cnt_q == DIV_CNT_W'(DIV_ITER - 1) ? FIX : BUSY;
            cnt_d   = cnt_q == DIV_CNT_W'(DIV_ITER - 1) ? cnt_q : cnt_q + 1'b1;
         end
         FIX: begin
            state_d = IDLE;
            if (!div_cancel) begin
               div_done = 1'b1;
               qres_d   = sgn_q ? -quo_q : quo_q;
               rres_d   = dsg_q ? -rem_q[DIV_WIDTH-1:0] : rem_q[DIV_WIDTH-1:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // results are visible combinationally during FIX and held by the result registers afterwards
   assign div_quotient  = qres_d;
   assign div_remainder = rres_d;
   assign div_busy      = state_q != IDLE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         sgn_q   <= 1'b0;
         dsg_q   <= 1'b0;
         qres_q  <= '0;
         rres_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         sgn_q   <= sgn_d;
         dsg_q   <= dsg_d;
         qres_q  <= qres_d;
         rres_q  <= rres_d;
      end
   end
endmodule
